inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 115 +++++++++++
 tb/tb_inst_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - streams bytes into instruction RAM as little-endian 32-bit words.
// The CPU holds fetch while busy is high; done pulses once per completed load.
module inst_loader #(
    parameter int IWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IWIDTH-1:0] start_adr,
    input  logic [IWIDTH:0]   word_cnt,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [IWIDTH-1:0] ram_wadr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wen,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_bidx;
    logic [IWIDTH:0]   r_remain;
    logic [IWIDTH-1:0] r_wadr;
    logic [31:0]       r_wdata;
    logic              w_accept;
    logic              w_last_word;
    logic              w_cnt_zero;

    assign w_accept    = (r_state == S_RECV) && byte_valid;
    assign w_last_word = (r_remain == (IWIDTH+1)'(1));
    assign w_cnt_zero  = (word_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_cnt_zero ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (w_accept && (r_bidx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: w_next = w_last_word ? S_DONE : S_RECV;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // abort outranks everything, but IDLE (including start+abort) ignores it
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bidx   <= 2'd0;
            r_remain <= '0;
            r_wadr   <= '0;
            r_wdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !w_cnt_zero) begin
                        r_wadr   <= start_adr;
                        r_remain <= word_cnt;
                        r_bidx   <= 2'd0;
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_wdata[{r_bidx, 3'b000} +: 8] <= byte_data;
                        r_bidx                         <= r_bidx + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (!abort && !w_last_word) begin
                        r_remain <= r_remain - 1'b1;
                        r_wadr   <= r_wadr + 1'b1;
                        r_bidx   <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs decode straight from state so the async reset clears them at once
    assign byte_ready = (r_state == S_RECV);
    assign ram_wen    = (r_state == S_WRITE) && !abort;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign ram_wadr   = r_wadr;
    assign ram_wdata  = r_wdata;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - randomized and directed bench for inst_loader.
// Writes, accepted bytes and done pulses are logged and compared to expected word lists.
module tb_inst_loader;
    localparam int IW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] start_adr;
    logic [IW:0]   word_cnt;
    logic          abort;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [IW-1:0] ram_wadr;
    logic [31:0]   ram_wdata;
    logic          ram_wen;
    logic          busy;
    logic          done;

    inst_loader #(.IWIDTH(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_adr  (start_adr),
        .word_cnt   (word_cnt),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .ram_wadr   (ram_wadr),
        .ram_wdata  (ram_wdata),
        .ram_wen    (ram_wen),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [IW-1:0] mon_adr[$];
    logic [31:0]   mon_data[$];
    int            mon_wcyc[$];
    int            mon_acyc[$];
    int            mon_done[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ram_wen) begin
                mon_adr.push_back(ram_wadr);
                mon_data.push_back(ram_wdata);
                mon_wcyc.push_back(cyc);
                check("bubble_ready", {63'd0, byte_ready}, 64'd0);
            end
            if (byte_valid && byte_ready) mon_acyc.push_back(cyc);
            if (done) mon_done.push_back(cyc);
        end
    end

    task automatic clear_mon();
        mon_adr.delete();
        mon_data.delete();
        mon_wcyc.delete();
        mon_acyc.delete();
        mon_done.delete();
    endtask

    function automatic void rand_bytes(input int nwords, output logic [7:0] b[$]);
        b.delete();
        for (int i = 0; i < 4 * nwords; i++) b.push_back(8'($urandom));
    endfunction

    task automatic start_load(input logic [IW-1:0] adr, input int cnt, input bit with_abort);
        clear_mon();
        @(posedge clk); #1;
        start     = 1'b1;
        start_adr = adr;
        word_cnt  = (IW+1)'(cnt);
        abort     = with_abort;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Offers bytes until stop_at are accepted; with gaps, valid toggles and stray starts are injected.
    task automatic feed(input logic [7:0] b[$], input int stop_at, input bit gaps);
        int  lim;
        int  got;
        int  budget;
        bit  acc;
        lim    = (stop_at >= 0) ? stop_at : b.size();
        got    = 0;
        budget = 0;
        while (got < lim && budget < 1000) begin
            byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_data  = b[got];
            start      = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
            start_adr  = IW'($urandom);
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (acc) got++;
            budget++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        check("feed_count", 64'(got), 64'(lim));
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic verify(input logic [IW-1:0] adr, input int exp_words,
                          input logic [7:0] b[$], input int exp_done);
        logic [IW-1:0] ea;
        logic [31:0]   ed;
        check("nwrites", 64'(mon_adr.size()), 64'(exp_words));
        for (int i = 0; i < exp_words && i < mon_adr.size(); i++) begin
            ea = IW'(adr + i);
            ed = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            check($sformatf("wadr%0d", i), 64'(mon_adr[i]), 64'(ea));
            check($sformatf("wdata%0d", i), 64'(mon_data[i]), 64'(ed));
            if (mon_acyc.size() > 4*i+3)
                check($sformatf("wen_lat%0d", i), 64'(mon_wcyc[i]), 64'(mon_acyc[4*i+3] + 1));
        end
        check("ndone", 64'(mon_done.size()), 64'(exp_done));
        if (exp_done > 0 && mon_done.size() > 0 && mon_wcyc.size() > 0)
            check("done_lat", 64'(mon_done[0]), 64'(mon_wcyc[mon_wcyc.size()-1] + 1));
    endtask

    initial begin
        logic [7:0]    b[$];
        logic [7:0]    b2[$];
        logic [IW-1:0] adr;
        int            cnt;

        rst_n      = 1'b0;
        start      = 1'b0;
        start_adr  = '0;
        word_cnt   = '0;
        abort      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        #12;
        check("rst_ready", {63'd0, byte_ready}, 64'd0);
        check("rst_wen", {63'd0, ram_wen}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_wadr", 64'(ram_wadr), 64'd0);
        check("rst_wdata", 64'(ram_wdata), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // bytes offered before any start must be ignored
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (5) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        check("pre_start_accepts", 64'(mon_acyc.size()), 64'd0);
        check("pre_start_busy", {63'd0, busy}, 64'd0);

        // single word
        b = '{8'h13, 8'h00, 8'h00, 8'h00};
        start_load(14'h010, 1, 1'b0);
        feed(b, -1, 1'b0);
        settle();
        verify(14'h010, 1, b, 1);

        // three words back-to-back, start issued together with abort
        rand_bytes(3, b);
        start_load(14'h100, 3, 1'b1);
        feed(b, -1, 1'b0);
        settle();
        verify(14'h100, 3, b, 1);

        // address wrap
        rand_bytes(2, b);
        start_load(14'h3FFF, 2, 1'b0);
        feed(b, -1, 1'b0);
        settle();
        verify(14'h3FFF, 2, b, 1);

        // zero-length load
        start_load(14'h055, 0, 1'b0);
        check("zero_busy", {63'd0, busy}, 64'd1);
        check("zero_done", {63'd0, done}, 64'd1);
        check("zero_wen", {63'd0, ram_wen}, 64'd0);
        @(posedge clk); #1;
        check("zero_busy_after", {63'd0, busy}, 64'd0);
        check("zero_done_after", {63'd0, done}, 64'd0);
        settle();
        check("zero_nwrites", 64'(mon_adr.size()), 64'd0);
        check("zero_ndone", 64'(mon_done.size()), 64'd1);

        // abort after two bytes of the second word
        rand_bytes(3, b);
        adr = IW'($urandom);
        start_load(adr, 3, 1'b0);
        feed(b, 6, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        settle();
        verify(adr, 1, b, 0);

        rand_bytes(2, b);
        start_load(14'h200, 2, 1'b0);
        feed(b, -1, 1'b0);
        settle();
        verify(14'h200, 2, b, 1);

        // abort in the write cycle suppresses the write
        rand_bytes(2, b);
        start_load(14'h300, 2, 1'b0);
        feed(b, 4, 1'b0);
        abort = 1'b1;
        #1;
        check("abort_write_wen", {63'd0, ram_wen}, 64'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        settle();
        verify(14'h300, 0, b, 0);

        // reset while in WRITE
        rand_bytes(2, b);
        start_load(14'h2A0, 2, 1'b0);
        feed(b, 4, 1'b0);
        check("pre_rst_wen", {63'd0, ram_wen}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_wen", {63'd0, ram_wen}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_ready", {63'd0, byte_ready}, 64'd0);
        check("async_rst_wadr", 64'(ram_wadr), 64'd0);
        clear_mon();
        @(posedge clk); #1;
        rst_n      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (6) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        check("post_rst_accepts", 64'(mon_acyc.size()), 64'd0);
        check("post_rst_writes", 64'(mon_adr.size()), 64'd0);
        check("post_rst_done", 64'(mon_done.size()), 64'd0);

        // randomized loads with valid gaps and stray starts
        for (int t = 0; t < 5; t++) begin
            cnt = $urandom_range(1, 4);
            adr = IW'($urandom);
            if (t == 0) adr = 14'h3FFE;
            rand_bytes(cnt, b2);
            start_load(adr, cnt, 1'b0);
            feed(b2, -1, 1'b1);
            settle();
            verify(adr, cnt, b2, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
